factorial_datapath: RTL and testbench



---
 rtl/factorial_datapath.sv | 146 ++++++++++++++
 tb/tb_factorial_datapath.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/factorial_datapath.sv
// factorial_datapath
// Iterative N! datapath driven by the factorial engine's pre/acc strobes.
// Each step multiplies the running product by the down-counter with a
// bit-serial shift-add multiplier: one launch cycle, NW accumulate cycles
// and one write-back cycle. The multiplier only advances while acc=1, so
// an engine pause freezes the step exactly where it stands.
module factorial_datapath #(
   parameter int NW = 5,
   parameter int PW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pre,
   input  logic          acc,
   input  logic          done,
   input  logic [NW-1:0] din,
   output logic          stop,
   output logic          busy,
   output logic [PW-1:0] dout,
   output logic          dout_vld,
   output logic          ovf
);

   // Bit-index width: enough to count 0..NW-1.
   localparam int BW = (NW > 1) ? $clog2(NW) : 1;
   // Full product width of a PW x NW multiply, so nothing is lost before
   // the overflow check at write-back.
   localparam int SW = PW + NW;

   localparam logic [1:0] M_IDLE = 2'd0;
   localparam logic [1:0] M_RUN  = 2'd1;
   localparam logic [1:0] M_WB   = 2'd2;

   localparam logic [NW-1:0] CNT_ONE   = NW'(1);
   localparam logic [BW-1:0] BIDX_ONE  = BW'(1);
   localparam logic [BW-1:0] BIDX_LAST = BW'(NW - 1);
   localparam logic [PW-1:0] PROD_ONE  = PW'(1);

   logic [NW-1:0] cnt_q,    cnt_d;
   logic [PW-1:0] prod_q,   prod_d;
   logic [PW-1:0] mcand_q,  mcand_d;
   logic [NW-1:0] mplier_q, mplier_d;
   logic [SW-1:0] sum_q,    sum_d;
   logic [BW-1:0] bidx_q,   bidx_d;
   logic          ovf_q,    ovf_d;
   logic [1:0]    mstate_q, mstate_d;

   // Multiplicand zero-extended to the full sum width and aligned to bit s.
   function automatic logic [SW-1:0] partial_product(input logic [PW-1:0] m,
                                                     input logic [BW-1:0] s);
      logic [SW-1:0] ext;
      ext = {{NW{1'b0}}, m};
      return ext << s;
   endfunction

   // True when the upper NW bits of a finished product are non-zero.
   function automatic logic exceeds_pw(input logic [SW-1:0] s);
      return |s[SW-1:PW];
   endfunction

   // Next-state logic: preload beats accumulate, and with neither strobe
   // every register holds (including a half-finished multiply).
   always_comb begin
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      sum_d    = sum_q;
      bidx_d   = bidx_q;
      ovf_d    = ovf_q;
      mstate_d = mstate_q;

      if (pre) begin
         // Abort anything in flight; the stale partial sum is simply
         // cleared again by the next launch.
         cnt_d    = din;
         prod_d   = PROD_ONE;
         ovf_d    = 1'b0;
         mstate_d = M_IDLE;
      end else if (acc) begin
         case (mstate_q)
            M_IDLE: begin
               if (cnt_q > CNT_ONE) begin
                  mcand_d  = prod_q;
                  mplier_d = cnt_q;
                  sum_d    = '0;
                  bidx_d   = '0;
                  mstate_d = M_RUN;
               end
            end
            M_RUN: begin
               if (mplier_q[bidx_q]) begin
                  sum_d = sum_q + partial_product(mcand_q, bidx_q);
               end
               bidx_d = bidx_q + BIDX_ONE;
               if (bidx_q == BIDX_LAST) begin
                  mstate_d = M_WB;
               end
            end
            M_WB: begin
               // Keep the truncated product and carry on; ovf records the loss.
               prod_d   = sum_q[PW-1:0];
               cnt_d    = cnt_q - CNT_ONE;
               ovf_d    = ovf_q | exceeds_pw(sum_q);
               mstate_d = M_IDLE;
            end
            default: begin
               mstate_d = M_IDLE;
            end
         endcase
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sum_q    <= '0;
         bidx_q   <= '0;
         ovf_q    <= 1'b0;
         mstate_q <= M_IDLE;
      end else begin
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sum_q    <= sum_d;
         bidx_q   <= bidx_d;
         ovf_q    <= ovf_d;
         mstate_q <= mstate_d;
      end
   end

   // Outputs are pure decodes of state so they stay put while acc is low.
   always_comb begin
      stop     = (cnt_q <= CNT_ONE) && (mstate_q == M_IDLE);
      busy     = (mstate_q != M_IDLE);
      dout     = prod_q;
      ovf      = ovf_q;
      dout_vld = done && stop;
   end

endmodule

// File: tb/tb_factorial_datapath.sv
// tb_factorial_datapath
// Table-driven and random checks of factorial_datapath against a plain
// arithmetic model of N! with PW-bit truncation per step.
module tb_factorial_datapath;

   localparam int NW = 5;
   localparam int PW = 32;
   localparam int STEP = NW + 2;
   localparam int BOUND = 1000;

   logic          clk;
   logic          rst;
   logic          pre;
   logic          acc;
   logic          done;
   logic [NW-1:0] din;
   logic          stop;
   logic          busy;
   logic [PW-1:0] dout;
   logic          dout_vld;
   logic          ovf;

   int n_vec = 0;
   int n_err = 0;

   logic [PW-1:0] exp_seq[$];

   typedef struct {
      int            n;
      logic [PW-1:0] exp_dout;
      logic          exp_ovf;
      int            exp_cyc;
   } vec_t;

   vec_t tbl[6];

   factorial_datapath #(.NW(NW), .PW(PW)) dut (
      .clk      (clk),
      .rst      (rst),
      .pre      (pre),
      .acc      (acc),
      .done     (done),
      .din      (din),
      .stop     (stop),
      .busy     (busy),
      .dout     (dout),
      .dout_vld (dout_vld),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: multiply down from n to 2, truncating to PW bits each step.
   task automatic model_fact(input int n, output logic [PW-1:0] d,
                             output logic o, output int cyc);
      logic [63:0] p;
      p = 64'd1;
      o = 1'b0;
      cyc = 0;
      exp_seq.delete();
      for (int k = n; k >= 2; k--) begin
         p = p * k;
         if (p >= 64'h1_0000_0000) o = 1'b1;
         p = p & 64'hFFFF_FFFF;
         exp_seq.push_back(p[PW-1:0]);
         cyc += STEP;
      end
      d = p[PW-1:0];
   endtask

   task automatic preload(input int n);
      pre = 1'b1;
      din = n[NW-1:0];
      @(posedge clk); #1;
      pre = 1'b0;
   endtask

   task automatic run_vec(input string tag, input int n, input logic [PW-1:0] e_d,
                          input logic e_o, input int e_c);
      logic [PW-1:0] prev;
      logic [PW-1:0] got[$];
      int cyc;
      bit seen_busy;
      logic [PW-1:0] md;
      logic mo;
      int mc;
      model_fact(n, md, mo, mc);
      done = 1'b0;
      acc = 1'b0;
      preload(n);
      chk({tag, " stop_after_pre"}, 64'(stop), 64'(n <= 1));
      chk({tag, " dout_after_pre"}, 64'(dout), 64'd1);
      chk({tag, " ovf_after_pre"}, 64'(ovf), 64'd0);
      acc = 1'b1;
      prev = dout;
      cyc = 0;
      seen_busy = busy;
      while (!stop && cyc < BOUND) begin
         @(posedge clk); #1;
         cyc++;
         if (busy) seen_busy = 1'b1;
         if (dout !== prev) begin
            got.push_back(dout);
            prev = dout;
         end
      end
      acc = 1'b0;
      done = 1'b1;
      #1;
      chk({tag, " cycles"}, 64'(cyc), 64'(e_c));
      chk({tag, " dout"}, 64'(dout), 64'(e_d));
      chk({tag, " ovf"}, 64'(ovf), 64'(e_o));
      chk({tag, " dout_vld"}, 64'(dout_vld), 64'd1);
      chk({tag, " busy_seen"}, 64'(seen_busy), 64'(n >= 2));
      chk({tag, " seq_len"}, 64'(got.size()), 64'(exp_seq.size()));
      for (int i = 0; i < got.size() && i < exp_seq.size(); i++)
         chk({tag, " seq"}, 64'(got[i]), 64'(exp_seq[i]));
      @(posedge clk); #1;
      chk({tag, " hold_dout"}, 64'(dout), 64'(e_d));
      done = 1'b0;
      #1;
      chk({tag, " vld_low"}, 64'(dout_vld), 64'd0);
   endtask

   initial begin
      logic [PW-1:0] rd;
      logic ro;
      int rc;
      int rn;
      int cyc;
      logic [PW-1:0] snap;

      tbl[0] = '{0,  32'd1,          1'b0, 0};
      tbl[1] = '{1,  32'd1,          1'b0, 0};
      tbl[2] = '{2,  32'd2,          1'b0, 7};
      tbl[3] = '{5,  32'd120,        1'b0, 28};
      tbl[4] = '{12, 32'd479001600,  1'b0, 77};
      tbl[5] = '{13, 32'd1932053504, 1'b1, 84};

      rst = 1'b1; pre = 1'b0; acc = 1'b0; done = 1'b0; din = '0;
      #12;
      chk("reset stop", 64'(stop), 64'd1);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset dout", 64'(dout), 64'd0);
      chk("reset ovf", 64'(ovf), 64'd0);
      chk("reset vld", 64'(dout_vld), 64'd0);
      done = 1'b1; #1;
      chk("reset vld_done", 64'(dout_vld), 64'd1);
      done = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 6; i++)
         run_vec($sformatf("tbl%0d", tbl[i].n), tbl[i].n, tbl[i].exp_dout,
                 tbl[i].exp_ovf, tbl[i].exp_cyc);

      for (int i = 0; i < 8; i++) begin
         rn = $urandom_range(0, 31);
         model_fact(rn, rd, ro, rc);
         run_vec($sformatf("rnd%0d", rn), rn, rd, ro, rc);
      end

      // Pause acc for five cycles inside step 2's accumulate phase.
      acc = 1'b0;
      preload(6);
      acc = 1'b1;
      cyc = 0;
      repeat (10) begin @(posedge clk); #1; cyc++; end
      snap = dout;
      acc = 1'b0;
      repeat (5) begin
         @(posedge clk); #1; cyc++;
         chk("pause dout", 64'(dout), 64'(snap));
         chk("pause busy", 64'(busy), 64'd1);
         chk("pause stop", 64'(stop), 64'd0);
      end
      acc = 1'b1;
      while (!stop && cyc < BOUND) begin @(posedge clk); #1; cyc++; end
      acc = 1'b0;
      chk("pause cycles", 64'(cyc), 64'(6 * STEP - STEP + 5));
      chk("pause dout_final", 64'(dout), 64'd720);

      // Abort a running multiply with a new preload (acc still high).
      preload(7);
      acc = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort busy_before", 64'(busy), 64'd1);
      pre = 1'b1; din = 5'd3;
      @(posedge clk); #1;
      pre = 1'b0;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort dout", 64'(dout), 64'd1);
      chk("abort stop", 64'(stop), 64'd0);
      cyc = 0;
      while (!stop && cyc < BOUND) begin @(posedge clk); #1; cyc++; end
      acc = 1'b0;
      chk("abort cycles", 64'(cyc), 64'(2 * STEP));
      chk("abort dout_final", 64'(dout), 64'd6);
      chk("abort ovf", 64'(ovf), 64'd0);

      // Asynchronous reset mid-cycle after an overflowing run.
      run_vec("pre_rst13", 13, 32'd1932053504, 1'b1, 84);
      @(posedge clk); #3;
      rst = 1'b1; #1;
      chk("arst ovf", 64'(ovf), 64'd0);
      chk("arst dout", 64'(dout), 64'd0);
      chk("arst stop", 64'(stop), 64'd1);
      #1 rst = 1'b0;

      // Asynchronous reset while a multiply is running.
      preload(6);
      acc = 1'b1;
      repeat (4) @(posedge clk);
      #3;
      chk("arst2 busy_before", 64'(busy), 64'd1);
      rst = 1'b1; #1;
      chk("arst2 busy", 64'(busy), 64'd0);
      chk("arst2 stop", 64'(stop), 64'd1);
      chk("arst2 dout", 64'(dout), 64'd0);
      acc = 1'b0;
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("arst2 hold_dout", 64'(dout), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
